cdu_mode_ctrl: RTL and testbench
================================

Name: cdu_mode_ctrl

Overview:
- Timing and moding sequencer for one CDU.
- Generates the four-phase drive set FAZ1DR..FAZ4DR. Arbitrates the AGC and ISS moding requests (zero, coarse align, error-counter enable) into a single mode state.
- Produces the active-low drive lines consumed by the CDU mode/phase buffer stage.
- All mode changes are aligned to the start of FAZ1, so channel logic never sees a mode change mid-cycle.

Parameters:
- PHASE_DIV, 2: clk cycles per phase. Legal range ≥1. One CDU cycle = 4*PHASE_DIV clks.
- ZERO_MIN, 4: minimum number of CDU cycles a ZERO episode lasts. Legal range ≥1.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- AGCZ  in  1  AGC zero request; level, active-high.
- ISSZ  in  1  ISS zero request; level, active-high.
- AGCCA  in  1  AGC coarse-align request; level.
- AGCEEC  in  1  AGC error-counter-enable request; level.
- FAZ1DR..FAZ4DR  out  1 each  phase drives, active-low, exactly one low when running.
- AGCZDR_n  out  1  AGC-zero drive, active-low.
- ISSZDR_n  out  1  ISS-zero drive, active-low. Feeds the per-channel A/B/C zero buffers.
- CADR_n  out  1  coarse-align drive, active-low.
- EECDR_n  out  1  error-counter-enable drive, active-low.
- MODE  out  2  current state: 0 IDLE, 1 ZERO, 2 COARSE, 3 FINE.
- CYCLE_STB  out  1  high for the first clk of every FAZ1.

Behaviour:
- All outputs are registered.
- Reset, asserted asynchronously:
  - FAZ1DR..4DR = 1, all *_n drives = 1, MODE = IDLE, CYCLE_STB = 0.
  - Phase is held at 4 with divider = PHASE_DIV-1, so the first edge after release enters phase 1.
  - Any in-progress episode is discarded.
- Phase generator:
  - Divider counts 0..PHASE_DIV-1. When it wraps, the phase advances 1→2→3→4→1.
  - FAZn DR is low for exactly PHASE_DIV clks. Phases are gap-free and never overlap.
- Boundary:
  - The boundary is the edge entering phase 1; CYCLE_STB is high on it.
  - The mode FSM samples the request inputs only at the boundary. Request pulses that do not span a boundary are ignored.
  - New MODE and drive values change on the same edge that FAZ1DR falls.
- FSM at each boundary, priority order zero > CA > EEC:
  - IDLE:
    - AGCZ|ISSZ → ZERO.
    - else AGCCA → COARSE.
    - else AGCEEC → FINE.
    - else stay.
  - ZERO, on entry:
    - Load the cycle counter with ZERO_MIN.
    - Latch the sticky source flags zA = AGCZ and zI = ISSZ.
  - ZERO, each later boundary:
    - Counter decrements, saturating at 0.
    - Flags OR in the current AGCZ and ISSZ.
    - Exit when counter = 0 and AGCZ = ISSZ = 0. Exit applies the IDLE evaluation on the same boundary, so ZERO can go directly to COARSE or FINE.
  - COARSE:
    - Zero request → ZERO.
    - else AGCCA = 0: AGCEEC → FINE, otherwise IDLE.
  - FINE:
    - Zero request → ZERO.
    - else AGCCA → COARSE.
    - else AGCEEC = 0 → IDLE.
- Drives:
  - AGCZDR_n = !(ZERO & zA).
  - ISSZDR_n = !(ZERO & zI).
  - CADR_n = !COARSE.
  - EECDR_n = !(COARSE | FINE).
- A ZERO episode lasts exactly max(ZERO_MIN, cycles for which a zero request is still seen at a boundary) CDU cycles.
- Counter width is $clog2(ZERO_MIN+1). Counts never wrap.

Decomposition:
- Package cdu_mode_pkg holds:
  - the mode_t enum (IDLE, ZERO, COARSE, FINE, encoded 0..3);
  - the phase index constants;
  - the CYCLE_CLKS helper function.
- Sub-module cdu_phase_gen (parameter PHASE_DIV):
  - Contains the divider, phase register, FAZ drives and CYCLE_STB.
  - Exports a boundary-enable pulse to the FSM.

Test Plan (PHASE_DIV=2, ZERO_MIN=4):
- Release reset with no requests → FAZ1DR low on clks 1-2, FAZ2DR 3-4, FAZ3DR 5-6, FAZ4DR 7-8, repeating every 8 clks. CYCLE_STB on clks 1, 9, 17, ... MODE = 0. All *_n = 1.
- AGCZ high for 3 clks spanning one boundary → MODE = 1 and AGCZDR_n = 0 for exactly 32 clks (4 cycles). ISSZDR_n stays 1. Then IDLE.
- ISSZ held 6 boundaries, AGCZ pulsed at the 2nd boundary only → ZERO lasts 6 cycles (48 clks). AGCZDR_n low from the 2nd boundary to the end, ISSZDR_n low throughout.
- AGCCA and AGCEEC both high → COARSE with CADR_n = 0 and EECDR_n = 0. Drop AGCCA mid-cycle → at the next boundary MODE = 3, CADR_n = 1, EECDR_n = 0.
- In COARSE, assert ISSZ at phase 3 → at the next boundary MODE = 1, ISSZDR_n = 0, CADR_n = 1 and EECDR_n = 1 on the same edge.
- Assert rst during phase 3 of ZERO → all FAZ and *_n outputs go to 1 with no clock edge. Release → FAZ1DR low on the first edge, MODE = 0, no ZERO residue.

Source files
------------

// File: rtl/cdu_mode_pkg.sv
// Shared types and constants for the CDU timing and moding sequencer.
package cdu_mode_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_ZERO   = 2'd1,
    MODE_COARSE = 2'd2,
    MODE_FINE   = 2'd3
  } mode_t;

  localparam logic [1:0] PHASE_1 = 2'd0;
  localparam logic [1:0] PHASE_2 = 2'd1;
  localparam logic [1:0] PHASE_3 = 2'd2;
  localparam logic [1:0] PHASE_4 = 2'd3;

  function automatic int cycle_clks(int phase_div);
    return 4 * phase_div;
  endfunction

endpackage

// File: rtl/cdu_phase_gen.sv
// Four-phase drive generator: divider, phase register, FAZ drives and cycle strobe.
module cdu_phase_gen #(
  parameter int PHASE_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] faz_n_o,
  output logic       cycle_stb_o,
  output logic       boundary_o
);
  import cdu_mode_pkg::*;

  localparam int DW = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    phase_q, phase_d;
  logic [3:0]    faz_n_q, faz_n_d;
  logic          stb_q;
  logic          div_wrap;

  assign div_wrap   = (div_q == DW'(PHASE_DIV - 1));
  // Combinational enable for the mode FSM: the coming edge enters phase 1.
  assign boundary_o = div_wrap && (phase_q == PHASE_4);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    div_d   = div_q;
    phase_d = phase_q;
    if (div_wrap) begin
      div_d   = '0;
      phase_d = (phase_q == PHASE_4) ? PHASE_1 : phase_q + 2'd1;
    end else begin
      div_d   = div_q + 1'b1;
    end
  end

  always_comb begin
    faz_n_d = 4'b1111;
    case (phase_d)
      PHASE_1: faz_n_d = 4'b1110;
      PHASE_2: faz_n_d = 4'b1101;
      PHASE_3: faz_n_d = 4'b1011;
      PHASE_4: faz_n_d = 4'b0111;
      default: faz_n_d = 4'b1111;
    endcase
  end

  // Reset parks the generator at the end of phase 4 so the first edge enters phase 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      div_q   <= DW'(PHASE_DIV - 1);
      phase_q <= PHASE_4;
      faz_n_q <= 4'b1111;
      stb_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      faz_n_q <= faz_n_d;
      stb_q   <= boundary_o;
    end
  end

  assign faz_n_o     = faz_n_q;
  assign cycle_stb_o = stb_q;

endmodule

// File: rtl/cdu_mode_ctrl.sv
// CDU timing and moding sequencer: phase drives plus boundary-aligned mode FSM.
module cdu_mode_ctrl #(
  parameter int PHASE_DIV = 2,
  parameter int ZERO_MIN  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       AGCZ,
  input  logic       ISSZ,
  input  logic       AGCCA,
  input  logic       AGCEEC,
  output logic       FAZ1DR,
  output logic       FAZ2DR,
  output logic       FAZ3DR,
  output logic       FAZ4DR,
  output logic       AGCZDR_n,
  output logic       ISSZDR_n,
  output logic       CADR_n,
  output logic       EECDR_n,
  output logic [1:0] MODE,
  output logic       CYCLE_STB
);
  import cdu_mode_pkg::*;

  localparam int CW = $clog2(ZERO_MIN + 1);

  mode_t         mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_dec;
  logic          za_q, za_d, zi_q, zi_d;
  logic [3:0]    drv_q, drv_d;
  logic [3:0]    faz_n;
  logic          boundary;
  logic          zero_req;

  cdu_phase_gen #(.PHASE_DIV(PHASE_DIV)) u_phase_gen (
    .clk         (clk),
    .rst         (rst),
    .faz_n_o     (faz_n),
    .cycle_stb_o (CYCLE_STB),
    .boundary_o  (boundary)
  );

  function automatic mode_t idle_eval(logic zr, logic ca, logic eec);
    if (zr)       return MODE_ZERO;
    else if (ca)  return MODE_COARSE;
    else if (eec) return MODE_FINE;
    else          return MODE_IDLE;
  endfunction

  assign zero_req = AGCZ | ISSZ;
  assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_IDLE;
      cnt_q  <= '0;
      za_q   <= 1'b0;
      zi_q   <= 1'b0;
      drv_q  <= 4'b1111;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      za_q   <= za_d;
      zi_q   <= zi_d;
      drv_q  <= drv_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    za_d   = za_q;
    zi_d   = zi_q;
    if (boundary) begin
      case (mode_q)
        MODE_IDLE: mode_d = idle_eval(zero_req, AGCCA, AGCEEC);
        MODE_ZERO: begin
          cnt_d = cnt_dec;
          za_d  = za_q | AGCZ;
          zi_d  = zi_q | ISSZ;
          if ((cnt_dec == '0) && !zero_req) mode_d = idle_eval(1'b0, AGCCA, AGCEEC);
        end
        MODE_COARSE: begin
          if (zero_req)   mode_d = MODE_ZERO;
          else if (!AGCCA) mode_d = AGCEEC ? MODE_FINE : MODE_IDLE;
        end
        MODE_FINE: begin
          if (zero_req)     mode_d = MODE_ZERO;
          else if (AGCCA)   mode_d = MODE_COARSE;
          else if (!AGCEEC) mode_d = MODE_IDLE;
        end
        default: mode_d = MODE_IDLE;
      endcase
      // Fresh episode: reload the minimum length and restart the sticky source flags.
      if ((mode_d == MODE_ZERO) && (mode_q != MODE_ZERO)) begin
        cnt_d = CW'(ZERO_MIN);
        za_d  = AGCZ;
        zi_d  = ISSZ;
      end
    end
  end

  always_comb begin
    drv_d = {!((mode_d == MODE_ZERO) && za_d),
             !((mode_d == MODE_ZERO) && zi_d),
             !(mode_d == MODE_COARSE),
             !((mode_d == MODE_COARSE) || (mode_d == MODE_FINE))};
  end

  assign {FAZ4DR, FAZ3DR, FAZ2DR, FAZ1DR}     = faz_n;
  assign {AGCZDR_n, ISSZDR_n, CADR_n, EECDR_n} = drv_q;
  assign MODE                                  = mode_q;

endmodule

// File: tb/tb_cdu_mode_ctrl.sv
// Self-checking bench for cdu_mode_ctrl: cycle-level behavioural model plus directed checks.
module tb_cdu_mode_ctrl;
  import cdu_mode_pkg::*;

  localparam int PD   = 2;
  localparam int ZMIN = 4;
  localparam int CYC  = cycle_clks(PD);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic AGCZ = 1'b0, ISSZ = 1'b0, AGCCA = 1'b0, AGCEEC = 1'b0;
  logic FAZ1DR, FAZ2DR, FAZ3DR, FAZ4DR;
  logic AGCZDR_n, ISSZDR_n, CADR_n, EECDR_n;
  logic [1:0] MODE;
  logic CYCLE_STB;

  int checks   = 0;
  int failures = 0;

  cdu_mode_ctrl #(.PHASE_DIV(PD), .ZERO_MIN(ZMIN)) dut (
    .clk(clk), .rst(rst),
    .AGCZ(AGCZ), .ISSZ(ISSZ), .AGCCA(AGCCA), .AGCEEC(AGCEEC),
    .FAZ1DR(FAZ1DR), .FAZ2DR(FAZ2DR), .FAZ3DR(FAZ3DR), .FAZ4DR(FAZ4DR),
    .AGCZDR_n(AGCZDR_n), .ISSZDR_n(ISSZDR_n), .CADR_n(CADR_n), .EECDR_n(EECDR_n),
    .MODE(MODE), .CYCLE_STB(CYCLE_STB)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: clks since reset release, boundary index, episode start, mode number, flags.
  typedef struct {
    int n;
    int bidx;
    int entry;
    int mode;
    bit za;
    bit zi;
  } mst_t;

  mst_t st;

  function automatic mst_t model_step(mst_t s, bit az, bit iz, bit ca, bit ee);
    mst_t r;
    bit   zr;
    bit   fresh;
    r     = s;
    zr    = az | iz;
    fresh = 1'b0;
    r.n   = s.n + 1;
    if (((r.n - 1) % CYC) == 0) begin
      r.bidx = s.bidx + 1;
      if (s.mode == 0) fresh = 1'b1;
      else if (s.mode == 1) begin
        r.za = s.za | az;
        r.zi = s.zi | iz;
        if ((r.bidx - s.entry) >= ZMIN && !zr) fresh = 1'b1;
      end else if (zr) begin
        r.mode = 1; r.entry = r.bidx; r.za = az; r.zi = iz;
      end else if (s.mode == 2) begin
        if (!ca) r.mode = ee ? 3 : 0;
      end else begin
        if (ca) r.mode = 2;
        else if (!ee) r.mode = 0;
      end
      if (fresh) begin
        if (zr) begin
          r.mode = 1; r.entry = r.bidx; r.za = az; r.zi = iz;
        end else if (ca) r.mode = 2;
        else if (ee)     r.mode = 3;
        else             r.mode = 0;
      end
    end
    return r;
  endfunction

  // Expected {FAZ4..1, AGCZDR_n, ISSZDR_n, CADR_n, EECDR_n, MODE, CYCLE_STB}.
  function automatic logic [10:0] model_out(mst_t s);
    logic [3:0] faz;
    logic       stb;
    int         p;
    if (s.n == 0) begin
      faz = 4'b1111;
      stb = 1'b0;
    end else begin
      p   = ((s.n - 1) / PD) % 4;
      faz = ~(4'b0001 << p);
      stb = (((s.n - 1) % CYC) == 0);
    end
    return {faz,
            !(s.mode == 1 && s.za), !(s.mode == 1 && s.zi),
            !(s.mode == 2), !(s.mode == 2 || s.mode == 3),
            2'(s.mode), stb};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) st <= '{n: 0, bidx: 0, entry: 0, mode: 0, za: 1'b0, zi: 1'b0};
    else     st <= model_step(st, AGCZ, ISSZ, AGCCA, AGCEEC);
  end

  int tot_zero = 0, tot_az = 0, tot_iz = 0;

  always @(negedge clk) begin
    check("cycle", {21'd0, FAZ4DR, FAZ3DR, FAZ2DR, FAZ1DR, AGCZDR_n, ISSZDR_n,
                    CADR_n, EECDR_n, MODE, CYCLE_STB}, {21'd0, model_out(st)});
    tot_zero <= tot_zero + ((MODE == 2'd1) ? 1 : 0);
    tot_az   <= tot_az + (AGCZDR_n ? 0 : 1);
    tot_iz   <= tot_iz + (ISSZDR_n ? 0 : 1);
  end

  task automatic goto_k(int k);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while ((((st.n - 1) % CYC) != k) && (i < 64));
    if (i >= 64) begin
      checks++;
      failures++;
      $display("FAIL goto_k timeout waiting for position %0d", k);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] faz_tab [8];
    int z0, a0, i0;
    faz_tab = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};

    repeat (3) @(negedge clk);
    check("reset_faz", {FAZ4DR, FAZ3DR, FAZ2DR, FAZ1DR}, 4'b1111);
    check("reset_drv", {AGCZDR_n, ISSZDR_n, CADR_n, EECDR_n}, 4'b1111);
    check("reset_mode", MODE, 2'd0);
    check("reset_stb", CYCLE_STB, 1'b0);
    rst = 1'b0;

    // Free-running phases with no requests.
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check("run_faz", {FAZ4DR, FAZ3DR, FAZ2DR, FAZ1DR}, faz_tab[(c - 1) % 8]);
      check("run_stb", CYCLE_STB, (c == 1 || c == 9) ? 1'b1 : 1'b0);
    end
    check("run_mode", MODE, 2'd0);
    check("run_drv", {AGCZDR_n, ISSZDR_n, CADR_n, EECDR_n}, 4'b1111);

    // Short AGCZ pulse spanning one boundary: minimum-length episode.
    z0 = tot_zero; a0 = tot_az; i0 = tot_iz;
    goto_k(6);
    AGCZ = 1'b1;
    repeat (3) @(negedge clk);
    AGCZ = 1'b0;
    repeat (40) @(negedge clk);
    check("z1_len", tot_zero - z0, 32);
    check("z1_agcz", tot_az - a0, 32);
    check("z1_issz", tot_iz - i0, 0);
    check("z1_idle", MODE, 2'd0);

    // ISSZ held six boundaries, AGCZ seen only at the second one.
    z0 = tot_zero; a0 = tot_az; i0 = tot_iz;
    goto_k(7);
    ISSZ = 1'b1;
    for (int b = 1; b <= 6; b++) begin
      if (b > 1) goto_k(7);
      if (b == 2) AGCZ = 1'b1;
      goto_k(0);
      AGCZ = 1'b0;
    end
    ISSZ = 1'b0;
    repeat (50) @(negedge clk);
    check("z2_len", tot_zero - z0, 48);
    check("z2_agcz", tot_az - a0, 40);
    check("z2_issz", tot_iz - i0, 48);

    // COARSE then FINE when AGCCA drops mid-cycle.
    goto_k(6);
    AGCCA = 1'b1; AGCEEC = 1'b1;
    goto_k(1);
    check("ca_mode", MODE, 2'd2);
    check("ca_drv", {CADR_n, EECDR_n}, 2'b00);
    goto_k(3);
    AGCCA = 1'b0;
    goto_k(1);
    check("fine_mode", MODE, 2'd3);
    check("fine_drv", {CADR_n, EECDR_n}, 2'b10);

    // Back to COARSE, then ISSZ at phase 3 pre-empts it at the next boundary.
    goto_k(6);
    AGCCA = 1'b1;
    goto_k(4);
    check("ca2_mode", MODE, 2'd2);
    ISSZ = 1'b1;
    goto_k(0);
    check("cz_mode", MODE, 2'd1);
    check("cz_drv", {AGCZDR_n, ISSZDR_n, CADR_n, EECDR_n}, 4'b1011);
    check("cz_edge", {FAZ1DR, CYCLE_STB}, 2'b01);
    ISSZ = 1'b0; AGCCA = 1'b0; AGCEEC = 1'b0;

    // Asynchronous reset in phase 3 of a ZERO episode.
    goto_k(4);
    #1 rst = 1'b1;
    #1;
    check("arst_faz", {FAZ4DR, FAZ3DR, FAZ2DR, FAZ1DR}, 4'b1111);
    check("arst_drv", {AGCZDR_n, ISSZDR_n, CADR_n, EECDR_n}, 4'b1111);
    check("arst_mode", MODE, 2'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_faz", {FAZ4DR, FAZ3DR, FAZ2DR, FAZ1DR}, 4'b1110);
    check("rel_stb", CYCLE_STB, 1'b1);
    check("rel_mode", MODE, 2'd0);
    check("rel_drv", {AGCZDR_n, ISSZDR_n}, 2'b11);
    repeat (24) @(negedge clk);
    check("rel_idle", MODE, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
